mc_sequencer: RTL and testbench
===============================

Name: mc_sequencer

Overview:
Parametrised multicycle control sequencer for the TiniSOC core. It drives the fetch / execute / memory / writeback strobes and the IM/DM enables, and replaces the fixed 4-state ring with ready/valid wait states for both memories. It adds a dedicated memory state entered only by load/store, configurable wait-state timeouts with a sticky error, halt at instruction boundaries, and a retired-instruction counter. It sits between the instruction decoder (which supplies mem_read/mem_write) and the datapath/memories.

Parameters:
IM_WAIT_MAX, 8, max cycles in FETCH without IM_ready before error; 0 disables the timeout
DM_WAIT_MAX, 8, max cycles in MEM without DM_ready before error; 0 disables the timeout
WAIT_W, 4, width of the wait counter; must satisfy 2^WAIT_W > max(IM_WAIT_MAX, DM_WAIT_MAX)
SKIP_WB_ON_STORE, 1, 1: a store returns to FETCH straight after MEM; 0: a store passes through WB
RET_W, 32, width of the retired-instruction counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
mem_read  in  1  decoded: current instruction is a load
mem_write  in  1  decoded: current instruction is a store
IM_ready  in  1  instruction memory data valid this cycle
DM_ready  in  1  data memory access complete this cycle
halt_req  in  1  request halt at next instruction boundary
enable_fetch  out  1  latch IR
enable_pc  out  1  advance PC
enable_execute  out  1  ALU/operand stage strobe
enable_writeback  out  1  register file write strobe
IM_enable, IM_read, IM_write  out  1 each  instruction memory controls; IM_write is tied 0
DM_enable, DM_read, DM_write  out  1 each  data memory controls
halted  out  1  sequencer is in HALT
error  out  1  sticky timeout/illegal error
state  out  3  current state encoding (debug)
retired  out  RET_W  count of completed instructions

Behaviour:
- States and encoding: IDLE=0, FETCH=1, LATCH=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
- All strobe outputs are Moore-decoded from the state register only. No output depends combinationally on any input.
- Reset (reset=0, asynchronous): state=IDLE, wait counter=0, retired=0. All outputs are 0 while reset is held and in IDLE. Reset mid-instruction aborts it with no further strobes.
- IDLE: transitions next cycle to HALT if halt_req=1, else to FETCH.
- FETCH: IM_enable=IM_read=1.
  - If IM_ready=1: go to LATCH and clear the wait counter.
  - Else: increment the wait counter.
  - Timeout: if IM_WAIT_MAX≠0 and the counter equals IM_WAIT_MAX-1 while IM_ready=0, go to ERR. A fetch therefore times out after exactly IM_WAIT_MAX non-ready cycles.
- LATCH: enable_fetch=enable_pc=1 for exactly one cycle, then EXEC.
- EXEC: enable_execute=1 for one cycle. mem_read and mem_write are sampled here.
  - Both 1: go to ERR.
  - Either 1: go to MEM.
  - Neither: go to WB.
- MEM: DM_enable=1, DM_read=mem_read, DM_write=mem_write. The decoder holds these stable because IR is stable.
  - On DM_ready=1, a load goes to WB. A store goes to FETCH (SKIP_WB_ON_STORE=1) or to WB (SKIP_WB_ON_STORE=0). The store counts as retired on that edge when it skips WB.
  - Timeout: same rule as FETCH, using DM_WAIT_MAX.
- WB: enable_writeback=1 for one cycle, and retired increments. Next state is HALT if halt_req=1, else FETCH.
- Halt sampling: halt_req is sampled only at instruction boundaries (IDLE, WB exit, and the store-skip exit from MEM). A halt_req pulse arriving mid-instruction and dropped before the boundary is ignored.
- HALT: halted=1, all strobes 0. Returns to FETCH on the first cycle halt_req=0.
- ERR: error=1, all strobes 0. Only reset leaves ERR.
- retired wraps modulo 2^RET_W with no saturation.
- Minimum instruction latency with ready asserted immediately:
  - ALU op: 4 cycles (FETCH, LATCH, EXEC, WB).
  - Load: 5 cycles.
  - Store: 4 cycles with SKIP_WB_ON_STORE=1, 5 cycles with SKIP_WB_ON_STORE=0.

Test Plan:
- Reset release, IM_ready=1, mem_read=mem_write=0: state sequence is 0,1,2,3,5,1,… and retired=1 after the first WB.
- Load, IM_ready=1, DM_ready held 0 for 3 cycles: MEM lasts 4 cycles with DM_read=1, then WB is reached; 5+3=8 cycles total.
- IM_ready stuck 0 with IM_WAIT_MAX=8: error=1 and state=7 entered after exactly 8 FETCH cycles; remains stuck until reset, then state=0.
- Store, SKIP_WB_ON_STORE=1: MEM→FETCH with no enable_writeback pulse and retired increments. Repeat with SKIP_WB_ON_STORE=0: the WB pulse is present.
- halt_req asserted during EXEC and held: WB completes, state=6, halted=1. Deassert: FETCH on the next cycle. A 1-cycle halt_req pulse in LATCH is ignored.
- Assert reset during MEM of a store: all outputs go 0 immediately; retired=0 after release.

Source files
------------

// File: rtl/mc_sequencer.sv
// ---------------------------------------------------------------------------
// mc_sequencer
//
// Multicycle control sequencer for the TiniSOC core. It steps one instruction
// at a time through FETCH -> LATCH -> EXEC -> (MEM) -> WB. The FETCH and MEM
// states wait on memory ready signals and have optional timeouts. Halts are
// taken only at instruction boundaries. A wrapping counter tracks the number
// of retired instructions.
//
// Handshake: IM_enable/IM_read (and DM_enable with DM_read/DM_write) stay
// asserted for as long as the sequencer is in FETCH (MEM). The access
// completes on the first rising edge at which IM_ready (DM_ready) is 1.
// There is no separate acceptance phase. Ready is ignored in all other
// states.
//
// Ports:
//   clock            rising-edge system clock
//   reset            asynchronous, active-low reset
//   mem_read         decoded load (sampled in EXEC)
//   mem_write        decoded store (sampled in EXEC)
//   IM_ready         instruction memory data valid
//   DM_ready         data memory access complete
//   halt_req         halt request, honoured at instruction boundaries
//   enable_fetch     latch IR (LATCH)
//   enable_pc        advance PC (LATCH)
//   enable_execute   ALU/operand stage strobe (EXEC)
//   enable_writeback register file write strobe (WB)
//   IM_enable/IM_read/IM_write  instruction memory controls (IM_write = 0)
//   DM_enable/DM_read/DM_write  data memory controls (MEM)
//   halted           sequencer is in HALT
//   error            sticky timeout / illegal-op error (ERR)
//   state            current state encoding, for debug
//   retired          completed-instruction count, wraps
// ---------------------------------------------------------------------------
module mc_sequencer #(
  parameter int IM_WAIT_MAX      = 8,
  parameter int DM_WAIT_MAX      = 8,
  parameter int WAIT_W           = 4,
  parameter int SKIP_WB_ON_STORE = 1,
  parameter int RET_W            = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             IM_ready,
  input  logic             DM_ready,
  input  logic             halt_req,
  output logic             enable_fetch,
  output logic             enable_pc,
  output logic             enable_execute,
  output logic             enable_writeback,
  output logic             IM_enable,
  output logic             IM_read,
  output logic             IM_write,
  output logic             DM_enable,
  output logic             DM_read,
  output logic             DM_write,
  output logic             halted,
  output logic             error,
  output logic [2:0]       state,
  output logic [RET_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_EXEC  = 3'd3,
    S_MEM   = 3'd4,
    S_WB    = 3'd5,
    S_HALT  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  // Counter value on the last allowed non-ready cycle. Only used when the
  // matching timeout is enabled (MAX != 0).
  localparam logic [WAIT_W-1:0] IM_LAST = WAIT_W'(IM_WAIT_MAX - 1);
  localparam logic [WAIT_W-1:0] DM_LAST = WAIT_W'(DM_WAIT_MAX - 1);
  localparam bit IM_TO_EN  = (IM_WAIT_MAX != 0);
  localparam bit DM_TO_EN  = (DM_WAIT_MAX != 0);
  localparam bit SKIP_WB   = (SKIP_WB_ON_STORE != 0);

  state_t            st;
  logic [WAIT_W-1:0] wait_cnt;
  // The load/store decision is captured in EXEC. This keeps the DM
  // controls free of any combinational path from the decoder inputs.
  logic              op_read;
  logic              op_write;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st       <= S_IDLE;
      wait_cnt <= '0;
      retired  <= '0;
      op_read  <= 1'b0;
      op_write <= 1'b0;
    end else begin
      case (st)
        S_IDLE: st <= halt_req ? S_HALT : S_FETCH;

        S_FETCH: begin
          if (IM_ready) begin
            st       <= S_LATCH;
            wait_cnt <= '0;
          end else if (IM_TO_EN && (wait_cnt == IM_LAST)) begin
            st       <= S_ERR;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_LATCH: st <= S_EXEC;

        S_EXEC: begin
          op_read  <= mem_read;
          op_write <= mem_write;
          if (mem_read && mem_write)      st <= S_ERR;
          else if (mem_read || mem_write) st <= S_MEM;
          else                            st <= S_WB;
        end

        S_MEM: begin
          if (DM_ready) begin
            wait_cnt <= '0;
            if (op_write && SKIP_WB) begin
              // A store that skips WB retires here, so this edge is also
              // an instruction boundary for halt sampling.
              retired <= retired + 1'b1;
              st      <= halt_req ? S_HALT : S_FETCH;
            end else begin
              st <= S_WB;
            end
          end else if (DM_TO_EN && (wait_cnt == DM_LAST)) begin
            st       <= S_ERR;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_WB: begin
          retired <= retired + 1'b1;
          st      <= halt_req ? S_HALT : S_FETCH;
        end

        S_HALT: if (!halt_req) st <= S_FETCH;

        S_ERR: st <= S_ERR;

        default: st <= S_ERR;
      endcase
    end
  end

  // Moore decode: depends only on the state register and the operation
  // bits captured in EXEC.
  always_comb begin
    enable_fetch     = 1'b0;
    enable_pc        = 1'b0;
    enable_execute   = 1'b0;
    enable_writeback = 1'b0;
    IM_enable        = 1'b0;
    IM_read          = 1'b0;
    DM_enable        = 1'b0;
    DM_read          = 1'b0;
    DM_write         = 1'b0;
    halted           = 1'b0;
    error            = 1'b0;
    case (st)
      S_FETCH: begin
        IM_enable = 1'b1;
        IM_read   = 1'b1;
      end
      S_LATCH: begin
        enable_fetch = 1'b1;
        enable_pc    = 1'b1;
      end
      S_EXEC:  enable_execute   = 1'b1;
      S_MEM: begin
        DM_enable = 1'b1;
        DM_read   = op_read;
        DM_write  = op_write;
      end
      S_WB:    enable_writeback = 1'b1;
      S_HALT:  halted           = 1'b1;
      S_ERR:   error            = 1'b1;
      default: ;
    endcase
  end

  assign IM_write = 1'b0;
  assign state    = st;

endmodule

// File: tb/tb_mc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mc_sequencer
//
// Directed bench. Two instances share the same stimulus:
//   u_a: default parameters.
//   u_b: IM timeout disabled, stores pass through WB, 2-bit retired counter.
// Inputs are driven 1 time unit after the rising edge, and outputs are
// sampled at that same point. Strobes are grouped into a 12-bit word:
//   [11] enable_fetch [10] enable_pc [9] enable_execute [8] enable_writeback
//   [7] IM_enable [6] IM_read [5] IM_write [4] DM_enable [3] DM_read
//   [2] DM_write [1] halted [0] error
// ---------------------------------------------------------------------------
module tb_mc_sequencer;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_LATCH = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5,
                         ST_HALT = 3'd6, ST_ERR = 3'd7;

  localparam logic [11:0] STB_NONE   = 12'h000;
  localparam logic [11:0] STB_FETCH  = 12'h0C0;
  localparam logic [11:0] STB_LATCH  = 12'hC00;
  localparam logic [11:0] STB_EXEC   = 12'h200;
  localparam logic [11:0] STB_WB     = 12'h100;
  localparam logic [11:0] STB_MEM_RD = 12'h018;
  localparam logic [11:0] STB_MEM_WR = 12'h014;
  localparam logic [11:0] STB_HALT   = 12'h002;
  localparam logic [11:0] STB_ERR    = 12'h001;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic mem_read = 1'b0, mem_write = 1'b0;
  logic IM_ready = 1'b0, DM_ready = 1'b0, halt_req = 1'b0;

  wire [11:0] a_stb, b_stb;
  wire [2:0]  a_state, b_state;
  wire [31:0] a_ret;
  wire [1:0]  b_ret;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mc_sequencer u_a (
    .clock(clock), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write),
    .IM_ready(IM_ready), .DM_ready(DM_ready), .halt_req(halt_req),
    .enable_fetch(a_stb[11]), .enable_pc(a_stb[10]),
    .enable_execute(a_stb[9]), .enable_writeback(a_stb[8]),
    .IM_enable(a_stb[7]), .IM_read(a_stb[6]), .IM_write(a_stb[5]),
    .DM_enable(a_stb[4]), .DM_read(a_stb[3]), .DM_write(a_stb[2]),
    .halted(a_stb[1]), .error(a_stb[0]),
    .state(a_state), .retired(a_ret)
  );

  mc_sequencer #(
    .IM_WAIT_MAX(0), .DM_WAIT_MAX(8), .WAIT_W(4),
    .SKIP_WB_ON_STORE(0), .RET_W(2)
  ) u_b (
    .clock(clock), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write),
    .IM_ready(IM_ready), .DM_ready(DM_ready), .halt_req(halt_req),
    .enable_fetch(b_stb[11]), .enable_pc(b_stb[10]),
    .enable_execute(b_stb[9]), .enable_writeback(b_stb[8]),
    .IM_enable(b_stb[7]), .IM_read(b_stb[6]), .IM_write(b_stb[5]),
    .DM_enable(b_stb[4]), .DM_read(b_stb[3]), .DM_write(b_stb[2]),
    .halted(b_stb[1]), .error(b_stb[0]),
    .state(b_state), .retired(b_ret)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
    IM_ready = 1'b0; DM_ready = 1'b0; halt_req = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    IM_ready = 1'b1;
    step();
    checks++; if (a_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", a_state, ST_IDLE); end
    checks++; if (a_stb !== STB_NONE) begin errors++; $display("FAIL reset_strobes: got %03h expected %03h", a_stb, STB_NONE); end
    checks++; if (a_ret !== 32'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", a_ret); end
    reset = 1'b1;
    IM_ready = 1'b0;
  endtask

  task automatic test_alu();
    logic [2:0]  exp_s [5] = '{ST_FETCH, ST_LATCH, ST_EXEC, ST_WB, ST_FETCH};
    logic [11:0] exp_b [5] = '{STB_FETCH, STB_LATCH, STB_EXEC, STB_WB, STB_FETCH};
    do_reset();
    IM_ready = 1'b1;
    checks++; if (a_state !== ST_IDLE) begin errors++; $display("FAIL alu_idle: got %0d expected %0d", a_state, ST_IDLE); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (a_state !== exp_s[i]) begin errors++; $display("FAIL alu_state[%0d]: got %0d expected %0d", i, a_state, exp_s[i]); end
      checks++; if (a_stb !== exp_b[i]) begin errors++; $display("FAIL alu_strobes[%0d]: got %03h expected %03h", i, a_stb, exp_b[i]); end
    end
    checks++; if (a_ret !== 32'd1) begin errors++; $display("FAIL alu_retired: got %0d expected 1", a_ret); end
  endtask

  // Continues from FETCH after test_alu (retired = 1).
  task automatic test_load();
    int cyc = 1;
    int mem_cyc = 0;
    int wb_cyc = 0;
    mem_read = 1'b1;
    DM_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (a_state === ST_FETCH) break;
      cyc++;
      if (a_state === ST_MEM) begin
        mem_cyc++;
        checks++; if (a_stb !== STB_MEM_RD) begin errors++; $display("FAIL load_mem_strobes: got %03h expected %03h", a_stb, STB_MEM_RD); end
        DM_ready = (mem_cyc == 4);
      end
      if (a_state === ST_WB) wb_cyc++;
    end
    DM_ready = 1'b0;
    mem_read = 1'b0;
    checks++; if (cyc !== 8) begin errors++; $display("FAIL load_latency: got %0d expected 8", cyc); end
    checks++; if (mem_cyc !== 4) begin errors++; $display("FAIL load_mem_cycles: got %0d expected 4", mem_cyc); end
    checks++; if (wb_cyc !== 1) begin errors++; $display("FAIL load_wb_cycles: got %0d expected 1", wb_cyc); end
    checks++; if (a_ret !== 32'd2) begin errors++; $display("FAIL load_retired: got %0d expected 2", a_ret); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (a_state !== ST_FETCH) begin errors++; $display("FAIL timeout_fetch[%0d]: got %0d expected %0d", i, a_state, ST_FETCH); end
    end
    step();
    checks++; if (a_state !== ST_ERR) begin errors++; $display("FAIL timeout_err_state: got %0d expected %0d", a_state, ST_ERR); end
    checks++; if (a_stb !== STB_ERR) begin errors++; $display("FAIL timeout_err_strobes: got %03h expected %03h", a_stb, STB_ERR); end
    checks++; if (b_state !== ST_FETCH || b_stb[0] !== 1'b0) begin errors++; $display("FAIL timeout_disabled: got state %0d error %0b expected state 1 error 0", b_state, b_stb[0]); end
    IM_ready = 1'b1;
    step(); step(); step();
    checks++; if (a_state !== ST_ERR || a_stb[0] !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got state %0d error %0b expected state 7 error 1", a_state, a_stb[0]); end
    do_reset();
    checks++; if (a_state !== ST_IDLE || a_stb !== STB_NONE) begin errors++; $display("FAIL timeout_cleared: got state %0d strobes %03h expected state 0 strobes 000", a_state, a_stb); end
  endtask

  task automatic test_illegal();
    do_reset();
    IM_ready = 1'b1;
    mem_read = 1'b1;
    mem_write = 1'b1;
    step(); step(); step();
    checks++; if (a_state !== ST_EXEC) begin errors++; $display("FAIL illegal_exec: got %0d expected %0d", a_state, ST_EXEC); end
    step();
    checks++; if (a_state !== ST_ERR || a_stb !== STB_ERR) begin errors++; $display("FAIL illegal_err: got state %0d strobes %03h expected state 7 strobes 001", a_state, a_stb); end
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic test_store();
    logic [2:0] exp_a [6] = '{ST_FETCH, ST_LATCH, ST_EXEC, ST_MEM, ST_FETCH, ST_LATCH};
    logic [2:0] exp_b [6] = '{ST_FETCH, ST_LATCH, ST_EXEC, ST_MEM, ST_WB, ST_FETCH};
    logic a_wb_seen = 1'b0;
    logic b_wb_seen = 1'b0;
    do_reset();
    IM_ready = 1'b1;
    mem_write = 1'b1;
    DM_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (a_state !== exp_a[i]) begin errors++; $display("FAIL store_skip_state[%0d]: got %0d expected %0d", i, a_state, exp_a[i]); end
      checks++; if (b_state !== exp_b[i]) begin errors++; $display("FAIL store_wb_state[%0d]: got %0d expected %0d", i, b_state, exp_b[i]); end
      if (a_stb[8] === 1'b1) a_wb_seen = 1'b1;
      if (b_stb[8] === 1'b1) b_wb_seen = 1'b1;
      if (i == 3) begin
        checks++; if (a_stb !== STB_MEM_WR) begin errors++; $display("FAIL store_mem_strobes: got %03h expected %03h", a_stb, STB_MEM_WR); end
      end
      if (i == 4) begin
        checks++; if (a_ret !== 32'd1) begin errors++; $display("FAIL store_skip_retired: got %0d expected 1", a_ret); end
      end
    end
    checks++; if (a_wb_seen !== 1'b0) begin errors++; $display("FAIL store_skip_no_wb: got %0b expected 0", a_wb_seen); end
    checks++; if (b_wb_seen !== 1'b1) begin errors++; $display("FAIL store_wb_pulse: got %0b expected 1", b_wb_seen); end
    checks++; if (b_ret !== 2'd1) begin errors++; $display("FAIL store_wb_retired: got %0d expected 1", b_ret); end
    mem_write = 1'b0;
    DM_ready = 1'b0;
  endtask

  task automatic test_halt();
    do_reset();
    IM_ready = 1'b1;
    step(); step();
    // One-cycle pulse during LATCH; it is gone before the WB boundary.
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    step(); step();
    checks++; if (a_state !== ST_FETCH) begin errors++; $display("FAIL halt_pulse_ignored: got %0d expected %0d", a_state, ST_FETCH); end
    step(); step();
    halt_req = 1'b1;
    step();
    checks++; if (a_state !== ST_WB || a_stb !== STB_WB) begin errors++; $display("FAIL halt_wb_completes: got state %0d strobes %03h expected state 5 strobes 100", a_state, a_stb); end
    step();
    checks++; if (a_state !== ST_HALT || a_stb !== STB_HALT) begin errors++; $display("FAIL halt_entered: got state %0d strobes %03h expected state 6 strobes 002", a_state, a_stb); end
    step();
    checks++; if (a_state !== ST_HALT) begin errors++; $display("FAIL halt_held: got %0d expected %0d", a_state, ST_HALT); end
    halt_req = 1'b0;
    step();
    checks++; if (a_state !== ST_FETCH) begin errors++; $display("FAIL halt_release: got %0d expected %0d", a_state, ST_FETCH); end
    // Halt requested while in IDLE.
    do_reset();
    halt_req = 1'b1;
    step();
    checks++; if (a_state !== ST_HALT) begin errors++; $display("FAIL halt_from_idle: got %0d expected %0d", a_state, ST_HALT); end
    halt_req = 1'b0;
  endtask

  task automatic test_reset_mid_store();
    do_reset();
    IM_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++; if (a_ret !== 32'd1) begin errors++; $display("FAIL midrst_pre_retired: got %0d expected 1", a_ret); end
    mem_write = 1'b1;
    step(); step(); step();
    checks++; if (a_state !== ST_MEM) begin errors++; $display("FAIL midrst_in_mem: got %0d expected %0d", a_state, ST_MEM); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (a_state !== ST_IDLE || a_stb !== STB_NONE || a_ret !== 32'd0) begin errors++; $display("FAIL midrst_async: got state %0d strobes %03h retired %0d expected 0 000 0", a_state, a_stb, a_ret); end
    mem_write = 1'b0;
    step();
    reset = 1'b1;
    step();
    checks++; if (a_state !== ST_FETCH || a_ret !== 32'd0) begin errors++; $display("FAIL midrst_release: got state %0d retired %0d expected 1 0", a_state, a_ret); end
  endtask

  task automatic test_back_to_back_wrap();
    do_reset();
    IM_ready = 1'b1;
    for (int i = 0; i < 17; i++) step();
    checks++; if (a_state !== ST_FETCH) begin errors++; $display("FAIL b2b_state: got %0d expected %0d", a_state, ST_FETCH); end
    checks++; if (a_ret !== 32'd4) begin errors++; $display("FAIL b2b_retired: got %0d expected 4", a_ret); end
    checks++; if (b_ret !== 2'd0) begin errors++; $display("FAIL b2b_retired_wrap: got %0d expected 0", b_ret); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_timeout();
    test_illegal();
    test_store();
    test_halt();
    test_reset_mid_store();
    test_back_to_back_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
